// File: rtl/sqrt_pkg.sv
// Shared constants for the integer square-root peripheral.
// Register map, CTRL/STATUS bit positions and FSM encoding.
package sqrt_pkg;

  localparam logic [4:0] ADDR_A_LO   = 5'h04;
  localparam logic [4:0] ADDR_A_HI   = 5'h08;
  localparam logic [4:0] ADDR_CTRL   = 5'h0C;
  localparam logic [4:0] ADDR_RESULT = 5'h10;
  localparam logic [4:0] ADDR_STATUS = 5'h14;
  localparam logic [4:0] ADDR_REM    = 5'h18;

  localparam int CTRL_START = 0;
  localparam int CTRL_CLR   = 1;
  localparam int ST_DONE    = 0;
  localparam int ST_BUSY    = 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sqrt_iter_core.sv
// Restoring square-root datapath: two operand bits in, one root bit out per step.
// root/rem are the combinational results of the current step.
module sqrt_iter_core #(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic                step,
  input  logic [DATA_W-1:0]   operand,
  output logic [DATA_W/2-1:0] root,
  output logic [DATA_W/2:0]   rem,
  output logic                last
);

  localparam int RW  = DATA_W / 2;
  localparam int ITW = $clog2(RW + 1);

  logic [DATA_W-1:0] a_q;
  logic [RW-1:0]     root_q;
  logic [RW:0]       rem_q;
  logic [ITW-1:0]    iter_q;

  logic [RW+2:0] sh;
  logic [RW+2:0] trial;
  logic [RW+2:0] diff;
  logic          ge;

  always_comb begin
    sh    = {rem_q, a_q[DATA_W-1 -: 2]};
    trial = {1'b0, root_q, 2'b01};
    diff  = sh - trial;
    ge    = (sh >= trial);
    root  = {root_q[RW-2:0], ge};
    rem   = (RW+1)'(ge ? diff : sh);
    last  = step && (iter_q == ITW'(1));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      a_q    <= '0;
      root_q <= '0;
      rem_q  <= '0;
      iter_q <= '0;
    end else if (load) begin
      a_q    <= operand;
      root_q <= '0;
      rem_q  <= '0;
      iter_q <= ITW'(RW);
    end else if (step) begin
      a_q    <= a_q << 2;
      root_q <= root;
      rem_q  <= rem;
      iter_q <= iter_q - ITW'(1);
    end
  end

endmodule

// File: rtl/peripheral_sqrt_gen.sv
// Memory-mapped iterative integer square root, parametrised operand width.
// Define SQRT_REM_EN to keep the remainder and expose it at 0x18.
module peripheral_sqrt_gen
  import sqrt_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] d_in,
  input  logic        cs,
  input  logic [4:0]  addr,
  input  logic        rd,
  input  logic        wr,
  output logic [31:0] d_out
);

  localparam int RW = DATA_W / 2;

  state_t state_q;
  state_t state_d;

  logic [DATA_W-1:0] operand_q;
  logic [RW-1:0]     root_q;
  logic [RW-1:0]     core_root;
  logic [31:0]       op32;
  logic [31:0]       rd_data;
  logic wr_en, rd_en, start, clr;
  logic load, step, last;
  logic busy, done;

`ifdef SQRT_REM_EN
  logic [RW:0] rem_q;
  logic [RW:0] core_rem;
`endif

  assign wr_en = cs & wr;
  assign rd_en = cs & rd & ~wr;
  assign start = wr_en && (addr == ADDR_CTRL) && d_in[CTRL_START];
  assign clr   = wr_en && (addr == ADDR_CTRL) && d_in[CTRL_CLR];
  assign busy  = (state_q == S_CALC);
  assign done  = (state_q == S_DONE);

  // High-half writes past DATA_W fall off on the truncation below.
  always_comb begin
    op32 = 32'(operand_q);
    if (wr_en && (addr == ADDR_A_LO)) op32[15:0] = d_in;
    if (wr_en && (addr == ADDR_A_HI)) op32[31:16] = d_in;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CALC;
          load    = 1'b1;
        end
      end
      S_CALC: begin
        step = 1'b1;
        if (last) state_d = S_DONE;
      end
      S_DONE: begin
        if (start) begin
          state_d = S_CALC;
          load    = 1'b1;
        end else if (clr) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  sqrt_iter_core #(
    .DATA_W (DATA_W)
  ) u_core (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .step    (step),
    .operand (operand_q),
    .root    (core_root),
`ifdef SQRT_REM_EN
    .rem     (core_rem),
`else
    .rem     (),
`endif
    .last    (last)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      operand_q <= '0;
      root_q    <= '0;
    end else begin
      operand_q <= op32[DATA_W-1:0];
      if (last) root_q <= core_root;
    end
  end

`ifdef SQRT_REM_EN
  always_ff @(posedge clk) begin
    if (!reset)    rem_q <= '0;
    else if (last) rem_q <= core_rem;
  end
`endif

  always_comb begin
    rd_data = '0;
    unique case (addr)
      ADDR_RESULT: rd_data = 32'(root_q);
      ADDR_STATUS: begin
        rd_data[ST_DONE] = done;
        rd_data[ST_BUSY] = busy;
      end
`ifdef SQRT_REM_EN
      ADDR_REM:    rd_data = 32'(rem_q);
`endif
      default:     rd_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) d_out <= '0;
    else        d_out <= rd_en ? rd_data : '0;
  end

endmodule

// File: tb/tb_peripheral_sqrt_gen.sv
// Bench for peripheral_sqrt_gen: transaction-level model plus directed literals.
// Remainder expectations follow the SQRT_REM_EN build define.
module tb_peripheral_sqrt_gen;

  localparam int DATA_W = 32;
  localparam int RW     = DATA_W / 2;

  localparam logic [4:0] A_LO = 5'h04;
  localparam logic [4:0] A_HI = 5'h08;
  localparam logic [4:0] CTRL = 5'h0C;
  localparam logic [4:0] RES  = 5'h10;
  localparam logic [4:0] STAT = 5'h14;
  localparam logic [4:0] REMA = 5'h18;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic        cs    = 1'b0;
  logic        rd    = 1'b0;
  logic        wr    = 1'b0;
  logic [15:0] d_in  = '0;
  logic [4:0]  addr  = '0;
  logic [31:0] d_out;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  peripheral_sqrt_gen #(.DATA_W(DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .d_in  (d_in),
    .cs    (cs),
    .addr  (addr),
    .rd    (rd),
    .wr    (wr),
    .d_out (d_out)
  );

  logic [31:0] m_op, m_work, m_root, m_rem, m_dout;
  logic        m_busy, m_done;
  logic        m_live = 1'b0;
  int          m_cnt;

  function automatic logic [31:0] isqrt(input logic [31:0] a);
    logic [63:0] r, t;
    r = 64'd0;
    for (int b = RW - 1; b >= 0; b--) begin
      t = r | (64'd1 << b);
      if (t * t <= 64'(a)) r = t;
    end
    return r[31:0];
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      RES:  return m_root;
      STAT: return {30'd0, m_busy, m_done};
`ifdef SQRT_REM_EN
      REMA: return m_rem;
`endif
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      m_op = 0; m_work = 0; m_root = 0; m_rem = 0;
      m_busy = 0; m_done = 0; m_cnt = 0; m_dout = 0;
      m_live = 1'b1;
    end else begin
      m_dout = (cs && rd && !wr) ? m_read(addr) : 32'd0;
      if (m_busy) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_busy = 0;
          m_done = 1;
          m_root = isqrt(m_work);
          m_rem  = m_work - m_root * m_root;
        end
      end else if (cs && wr && addr == CTRL && d_in[0]) begin
        m_work = m_op;
        m_busy = 1;
        m_done = 0;
        m_cnt  = RW;
      end else if (cs && wr && addr == CTRL && d_in[1]) begin
        m_done = 0;
      end
      if (cs && wr && addr == A_LO) m_op[15:0] = d_in;
      if (cs && wr && addr == A_HI) m_op[31:16] = d_in;
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      n_cmp++;
      if (d_out !== m_dout) begin
        n_bad++;
        $display("FAIL cycle_dout t=%0t: got %h want %h", $time, d_out, m_dout);
      end
    end
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask

  task automatic wr_reg(input logic [4:0] a, input logic [15:0] d);
    cs = 1; wr = 1; rd = 0; addr = a; d_in = d;
    @(negedge clk);
    cs = 0; wr = 0;
  endtask

  task automatic rd_reg(input logic [4:0] a, output logic [31:0] v);
    cs = 1; rd = 1; wr = 0; addr = a;
    @(negedge clk);
    v = d_out;
    cs = 0; rd = 0;
  endtask

  task automatic rd_chk(input string n, input logic [4:0] a, input logic [31:0] e);
    logic [31:0] v;
    rd_reg(a, v);
    chk(n, v, e);
  endtask

  // Polls STATUS; cyc = number of reads issued until done was seen.
  task automatic wait_done(input string n, output int cyc);
    logic [31:0] v;
    cyc = 0;
    do begin
      rd_reg(STAT, v);
      cyc++;
    end while (!v[0] && cyc < 40);
    if (!v[0]) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: done=0 after %0d polls, want done=1", n, cyc);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic [31:0] v;
    reset = 0;
    repeat (2) @(negedge clk);
    reset = 1;

    rd_chk("rst_result", RES, 32'd0);
    rd_chk("rst_status", STAT, 32'd0);
    rd_chk("rst_rem", REMA, 32'd0);
    rd_chk("unmapped_00", 5'h00, 32'd0);

    // 144: read data lags one edge, so done shows on poll 17
    wr_reg(A_LO, 16'h0090);
    wr_reg(A_HI, 16'h0000);
    wr_reg(CTRL, 16'h0001);
    wait_done("t1", cyc);
    chk("t1_latency", cyc - 1, 16);
    rd_chk("t1_result", RES, 32'd12);
    rd_chk("t1_rem", REMA, 32'd0);
    rd_chk("t1_status", STAT, 32'h1);
    chk("t1_model_root", m_root, 32'd12);

    wr_reg(A_HI, 16'hFFFF);
    wr_reg(A_LO, 16'hFFFF);
    wr_reg(CTRL, 16'h0001);
    wait_done("t2", cyc);
    rd_chk("t2_result", RES, 32'h0000FFFF);
`ifdef SQRT_REM_EN
    rd_chk("t2_rem", REMA, 32'h0001FFFE);
`else
    rd_chk("t2_rem_off", REMA, 32'd0);
`endif
    chk("t2_model_rem", m_rem, 32'h0001FFFE);

    wr_reg(A_LO, 16'h0000);
    wr_reg(A_HI, 16'h0000);
    wr_reg(CTRL, 16'h0001);
    rd_chk("t3_status_busy", STAT, 32'h2);
    wait_done("t3", cyc);
    chk("t3_latency", cyc, 16);
    rd_chk("t3_result", RES, 32'd0);
    rd_chk("t3_rem", REMA, 32'd0);

    wr_reg(A_LO, 16'h0090);
    wr_reg(CTRL, 16'h0001);
    repeat (3) @(negedge clk);
    wr_reg(A_LO, 16'h0031);
    wr_reg(CTRL, 16'h0001);
    wait_done("t4a", cyc);
    rd_chk("t4_result_kept", RES, 32'd12);
    wr_reg(CTRL, 16'h0001);
    wait_done("t4b", cyc);
    rd_chk("t4_result_new", RES, 32'd7);
    rd_chk("t4_rem_new", REMA, 32'd0);

    wr_reg(A_LO, 16'd50);
    wr_reg(CTRL, 16'h0001);
    repeat (7) @(negedge clk);
    reset = 0;
    @(negedge clk);
    reset = 1;
    rd_chk("t5_status_rst", STAT, 32'd0);
    rd_chk("t5_result_rst", RES, 32'd0);
    wr_reg(A_LO, 16'd50);
    wr_reg(CTRL, 16'h0001);
    wait_done("t5", cyc);
    rd_chk("t5_result", RES, 32'd7);
`ifdef SQRT_REM_EN
    rd_chk("t5_rem", REMA, 32'd1);
`else
    rd_chk("t5_rem_off", REMA, 32'd0);
`endif
    chk("t5_model_rem", m_rem, 32'd1);

    wr_reg(CTRL, 16'h0002);
    rd_chk("t6_status_clr", STAT, 32'd0);
    rd_chk("t6_result_held", RES, 32'd7);

    wr_reg(CTRL, 16'h0001);
    wait_done("t7a", cyc);
    wr_reg(CTRL, 16'h0003);
    rd_chk("t7_start_wins", STAT, 32'h2);
    wait_done("t7b", cyc);
    rd_chk("t7_result", RES, 32'd7);

    // Read and write together: write lands, read data is zero
    cs = 1; rd = 1; wr = 1; addr = A_LO; d_in = 16'd100;
    @(negedge clk);
    v = d_out;
    cs = 0; rd = 0; wr = 0;
    chk("t8_rdwr_dout", v, 32'd0);
    wr_reg(CTRL, 16'h0001);
    wait_done("t8", cyc);
    rd_chk("t8_result", RES, 32'd10);
    rd_chk("unmapped_1c", 5'h1C, 32'd0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
